// File: rtl/sw_alloc_rr.sv
// sw_alloc_rr: switch allocator with one round-robin arbiter per output.
// Each output runs a FREE/BUSY lock held until the owner's CROSS_DONE,
// so several non-conflicting input->output connections can coexist.
// Optional build macro: SA_TIMEOUT_EN adds a per-output BUSY watchdog
// that force-releases a stuck lock after TIMEOUT_CYC cycles.
module sw_alloc_rr #(
  parameter int unsigned NUM_PORTS   = 5,
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_PORTS-1:0]       REQ_VALID,
  input  logic [NUM_PORTS*SEL_W-1:0] REQ_DST,
  input  logic [NUM_PORTS-1:0]       CROSS_DONE,
  output logic [NUM_PORTS-1:0]       GRANT,
  output logic [NUM_PORTS-1:0]       OUT_VALID,
  output logic [NUM_PORTS*SEL_W-1:0] OUT_SEL,
  output logic                       CROSS_EN,
  output logic                       TIMEOUT_ERR
);

  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} state_e;

  state_e               state [NUM_PORTS];
  logic [SEL_W-1:0]     owner [NUM_PORTS];
  logic [SEL_W-1:0]     ptr   [NUM_PORTS];

  logic [NUM_PORTS-1:0] elig  [NUM_PORTS];
  logic [NUM_PORTS-1:0] found;
  logic [SEL_W-1:0]     win   [NUM_PORTS];
  logic [NUM_PORTS-1:0] owner_done;
  logic [NUM_PORTS-1:0] tmo;
  logic [NUM_PORTS-1:0] rel;
  logic [NUM_PORTS-1:0] grant_set;
  logic [NUM_PORTS-1:0] grant_clr;

  // Index base+k folded back into 0..NUM_PORTS-1 (base < NUM_PORTS, k < NUM_PORTS).
  function automatic int unsigned wrap_idx(input logic [SEL_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return s;
  endfunction

  // Eligible requesters per output: valid, aimed here, and not already holding an output.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      elig[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        elig[o][i] = REQ_VALID[i] && !GRANT[i] &&
                     (REQ_DST[i*SEL_W +: SEL_W] == SEL_W'(o));
      end
    end
  end

  // Round-robin pick: first eligible index scanning upward from ptr.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      found[o] = 1'b0;
      win[o]   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!found[o] && elig[o][wrap_idx(ptr[o], 32'(k))]) begin
          found[o] = 1'b1;
          win[o]   = SEL_W'(wrap_idx(ptr[o], 32'(k)));
        end
      end
    end
  end

  // Release conditions and the per-input grant set/clear masks.
  always_comb begin
    owner_done = '0;
    grant_set  = '0;
    grant_clr  = '0;
    rel        = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (owner[o] == SEL_W'(i) && CROSS_DONE[i]) owner_done[o] = 1'b1;
      end
      rel[o] = (state[o] == BUSY) && (owner_done[o] || tmo[o]);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (state[o] == FREE && found[o] && win[o] == SEL_W'(i)) grant_set[i] = 1'b1;
        if (rel[o] && owner[o] == SEL_W'(i))                     grant_clr[i] = 1'b1;
      end
    end
  end

  // Per-output lock FSM with registered GRANT/OUT_VALID/OUT_SEL.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state[o] <= FREE;
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
      GRANT     <= '0;
      OUT_VALID <= '0;
      OUT_SEL   <= '1;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (state[o])
          FREE: begin
            if (found[o]) begin
              state[o]                  <= BUSY;
              owner[o]                  <= win[o];
              OUT_VALID[o]              <= 1'b1;
              OUT_SEL[o*SEL_W +: SEL_W] <= win[o];
            end
          end
          BUSY: begin
            if (rel[o]) begin
              state[o]                  <= FREE;
              OUT_VALID[o]              <= 1'b0;
              OUT_SEL[o*SEL_W +: SEL_W] <= '1;
              ptr[o] <= (owner[o] == SEL_W'(NUM_PORTS - 1)) ? '0 : owner[o] + SEL_W'(1);
            end
          end
          default: state[o] <= FREE;
        endcase
      end
      GRANT <= (GRANT & ~grant_clr) | grant_set;
    end
  end

  // Crossbar enable follows the registered per-output valids.
  assign CROSS_EN = |OUT_VALID;

`ifdef SA_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt [NUM_PORTS];

  // Watchdog fires on the edge that completes TIMEOUT_CYC busy cycles.
  always_comb begin
    tmo = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      tmo[o] = (state[o] == BUSY) && !owner_done[o] &&
               (cnt[o] == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  // BUSY age per output, cleared while FREE (hence on grant), saturating.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int o = 0; o < NUM_PORTS; o++) cnt[o] <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (state[o] == FREE)                     cnt[o] <= '0;
        else if (cnt[o] != CNT_W'(TIMEOUT_CYC))   cnt[o] <= cnt[o] + CNT_W'(1);
      end
      TIMEOUT_ERR <= |tmo;
    end
  end
`else
  logic unused_cfg;

  assign tmo         = '0;
  assign TIMEOUT_ERR = 1'b0;
  assign unused_cfg  = ^32'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_sw_alloc_rr.sv
// tb_sw_alloc_rr: directed and random checks of sw_alloc_rr against a
// behavioural model of per-output packet locks and round-robin pointers.
`timescale 1ns/1ps
module tb_sw_alloc_rr;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int TO = 8;
`ifdef SA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*SW-1:0] req_dst;
  logic [N-1:0]  cross_done;
  logic [N-1:0]  grant;
  logic [N-1:0]  out_valid;
  logic [N*SW-1:0] out_sel;
  logic          cross_en;
  logic          timeout_err;

  sw_alloc_rr #(.NUM_PORTS(N), .SEL_W(SW), .TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_DST(req_dst), .CROSS_DONE(cross_done),
    .GRANT(grant), .OUT_VALID(out_valid), .OUT_SEL(out_sel),
    .CROSS_EN(cross_en), .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus variables.
  bit [N-1:0] rv;
  bit [N-1:0] cd;
  int         dst [N];

  // Model: owner per output (-1 = free), pointer, busy age, watchdog pulse.
  int m_owner [N];
  int m_ptr   [N];
  int m_age   [N];
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    req_valid  = rv;
    cross_done = cd;
    for (int i = 0; i < N; i++) req_dst[i*SW +: SW] = SW'(dst[i]);
  endtask

  task automatic model_reset();
    for (int o = 0; o < N; o++) begin
      m_owner[o] = -1;
      m_ptr[o]   = 0;
      m_age[o]   = 0;
    end
    m_err = 1'b0;
  endtask

  // One clock edge of the allocator as described by its rules.
  task automatic model_edge();
    bit holding [N];
    bit err;
    for (int i = 0; i < N; i++) holding[i] = 1'b0;
    for (int o = 0; o < N; o++) if (m_owner[o] >= 0) holding[m_owner[o]] = 1'b1;
    err = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (m_owner[o] >= 0) begin
        if (cd[m_owner[o]]) begin
          m_ptr[o]   = (m_owner[o] + 1) % N;
          m_owner[o] = -1;
        end else begin
          m_age[o]++;
          if (TO_EN && m_age[o] >= TO) begin
            m_ptr[o]   = (m_owner[o] + 1) % N;
            m_owner[o] = -1;
            err        = 1'b1;
          end
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr[o] + k) % N;
          if (rv[c] && dst[c] == o && !holding[c]) begin
            m_owner[o] = c;
            m_age[o]   = 0;
            break;
          end
        end
      end
    end
    m_err = err;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]    eg;
    logic [N-1:0]    ev;
    logic [N*SW-1:0] es;
    eg = '0;
    ev = '0;
    es = '1;
    for (int o = 0; o < N; o++) begin
      if (m_owner[o] >= 0) begin
        eg[m_owner[o]]   = 1'b1;
        ev[o]            = 1'b1;
        es[o*SW +: SW]   = SW'(m_owner[o]);
      end
    end
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    check({tag, "_valid"}, 32'(out_valid), 32'(ev));
    check({tag, "_sel"}, 32'(out_sel), 32'(es));
    check({tag, "_en"}, 32'(cross_en), 32'(|ev));
    check({tag, "_tmo"}, 32'(timeout_err), 32'(m_err));
  endtask

  // Drive, take one edge, update model, then compare 1 ns after the edge.
  task automatic tick(input string tag);
    apply_inputs();
    @(posedge clk);
    model_edge();
    #1;
    cd = '0;
    apply_inputs();
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_sel"}, 32'(out_sel), 32'h7fff);
    check({tag, "_en"}, 32'(cross_en), 32'h0);
    check({tag, "_tmo"}, 32'(timeout_err), 32'h0);
  endtask

  int exp_order [4] = '{2, 3, 4, 2};

  initial begin
    rst = 1'b1;
    rv  = '0;
    cd  = '0;
    for (int i = 0; i < N; i++) dst[i] = 0;
    apply_inputs();
    model_reset();
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // 1: single W->E packet, then release.
    rv = 5'b00001; dst[0] = 1;
    tick("t1a");
    check("t1_grant", 32'(grant), 32'b00001);
    check("t1_sel1", 32'(out_sel[5:3]), 32'd0);
    check("t1_valid", 32'(out_valid), 32'b00010);
    check("t1_en", 32'(cross_en), 32'd1);
    rv = '0; cd = 5'b00001;
    tick("t1b");
    check("t1_rel_sel1", 32'(out_sel[5:3]), 32'd7);
    check("t1_rel_valid", 32'(out_valid), 32'd0);

    // 2: three disjoint connections granted on the same edge.
    rv = 5'b10011; dst[0] = 2; dst[1] = 3; dst[4] = 0;
    tick("t2a");
    check("t2_grant", 32'(grant), 32'b10011);
    check("t2_sel2", 32'(out_sel[8:6]), 32'd0);
    check("t2_sel3", 32'(out_sel[11:9]), 32'd1);
    check("t2_sel0", 32'(out_sel[2:0]), 32'd4);
    tick("t2b");
    tick("t2c");
    // Asynchronous reset mid-packet, away from any clock edge.
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("t2_async_rst");
    rv = '0;
    apply_inputs();
    #2 rst = 1'b0;

    // 3: N, S, PE contend for PE; round-robin order with one idle gap.
    rv = 5'b11100; dst[2] = 4; dst[3] = 4; dst[4] = 4;
    for (int p = 0; p < 4; p++) begin
      tick("t3g");
      check("t3_order", 32'(out_sel[14:12]), 32'(exp_order[p]));
      tick("t3h");
      tick("t3h");
      cd[exp_order[p]] = 1'b1;
      if (p == 3) rv = '0;
      tick("t3r");
      check("t3_gap", 32'(out_valid[4]), 32'd0);
    end

    // 4: lock held despite request changes; stray CROSS_DONE ignored.
    rv = 5'b00001; dst[0] = 1;
    tick("t4a");
    rv = '0; dst[0] = 3; cd = 5'b00100;
    tick("t4b");
    check("t4_hold_grant", 32'(grant[0]), 32'd1);
    check("t4_hold_sel", 32'(out_sel[5:3]), 32'd0);
    repeat (3) tick("t4c");
    cd = 5'b00001;
    tick("t4d");
    check("t4_rel", 32'(out_valid[1]), 32'd0);

    // 5: out-of-range destinations never granted.
    rv = 5'b00011; dst[0] = 5; dst[1] = 7;
    for (int c = 0; c < 20; c++) begin
      tick("t5");
      check("t5_no_valid", 32'(out_valid), 32'd0);
    end
    rv = '0;

    // 6: watchdog release, or indefinite hold without it.
    rv = 5'b00001; dst[0] = 1;
    tick("t6a");
    check("t6_grant", 32'(grant), 32'b00001);
`ifdef SA_TIMEOUT_EN
    rv = 5'b01001; dst[3] = 1;
    repeat (7) tick("t6b");
    check("t6_pre_tmo", 32'(timeout_err), 32'd0);
    tick("t6c");
    check("t6_tmo", 32'(timeout_err), 32'd1);
    check("t6_tmo_rel", 32'(out_valid[1]), 32'd0);
    tick("t6d");
    check("t6_next", 32'(grant), 32'b01000);
    check("t6_tmo_pulse", 32'(timeout_err), 32'd0);
    rv = '0; cd = 5'b01000;
    tick("t6e");
`else
    repeat (100) tick("t6b");
    check("t6_held", 32'(grant[0]), 32'd1);
    check("t6_tmo_zero", 32'(timeout_err), 32'd0);
    rv = '0; cd = 5'b00001;
    tick("t6e");
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rv = N'($urandom);
      for (int i = 0; i < N; i++)
        dst[i] = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      cd = N'($urandom & $urandom);
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
